exp_isi_spike_gen: RTL
======================

Name: exp_isi_spike_gen

Overview:
- Downstream consumer of the exponential PRNG stage.
- Treats each signed fixed-point exponential sample as a Poisson inter-spike interval (ISI), scales it by a programmable rate factor and counts it down.
- Emits a spike event on a valid/ready handshake, then applies an optional refractory period.
- Produces Poisson spike trains for the neuron-array input fabric.

Parameters:
- X_WID, 16, width of signed input sample (two's complement).
- FRAC_WID, 8, fractional bits in sample_i.
- SCALE_WID, 8, width of unsigned scale_i.
- CNT_WID, 16, width of ISI counter and isi_o.
- REFRAC_WID, 8, width of refrac_i and the refractory counter.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- en_i  in  1  generator enable
- sample_i  in  X_WID  signed exponential sample, free-running, valid every cycle
- scale_i  in  SCALE_WID  cycles per unit of sample (mean ISI = scale_i cycles)
- refrac_i  in  REFRAC_WID  refractory cycles after each accepted spike; 0 = none
- spike_o  out  1  spike event valid
- spike_ready_i  in  1  downstream accepts spike
- isi_o  out  CNT_WID  interval N that produced the current spike; stable while spike_o=1
- busy_o  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, active-high): state=IDLE, spike_o=0, isi_o=0, busy_o=0, all counters 0.
- Interval arithmetic:
  - s = max(sample_i, 0), so negative samples clamp to 0.
  - p = s * scale_i, full width X_WID+SCALE_WID.
  - N = p >> FRAC_WID, truncating.
  - If N > 2^CNT_WID-1, N = 2^CNT_WID-1 (saturate).
  - If N == 0, N = 1.
- FSM states: IDLE, LOAD, COUNT, FIRE, REFRAC.
- IDLE: if en_i -> LOAD.
- LOAD: one cycle. sample_i and scale_i are captured at the closing edge, counter := N, isi register := N -> COUNT.
- COUNT: counter decrements every cycle.
  - If en_i=0 -> IDLE next cycle; spike discarded, counter cleared.
  - Else if counter==1 -> FIRE. COUNT lasts exactly N cycles.
- FIRE: spike_o=1, isi_o=isi register. Held until spike_ready_i=1; en_i is ignored (a pending spike is never dropped).
  - On handshake with refrac_i!=0: REFRAC, counter := refrac_i sampled at the handshake edge.
  - On handshake with refrac_i==0: LOAD if en_i, else IDLE.
  - spike_o is deasserted the cycle after handshake.
- REFRAC: decrements each cycle. When counter==1, go to LOAD if en_i, else IDLE. en_i deassertion does not abort REFRAC.
- Latency: en_i high at cycle 0 (IDLE) -> LOAD cycle 1 -> COUNT cycles 2..N+1 -> spike_o high from cycle N+2.
- Back-to-back, zero refrac, ready held high: spike period = N+2 cycles (FIRE + LOAD + N).
- spike_ready_i outside FIRE is ignored.
- scale_i and refrac_i changes take effect only at their capture points.
- Reset mid-operation returns to reset values immediately, asynchronously.

Optional Feature:
- Macro SPIKE_CNT_EN.
- Defined:
  - Adds output spike_cnt_o (16 bits), incremented on each accepted handshake.
  - Saturates at 0xFFFF.
  - Cleared by rst_i, or synchronously when en_i falls (1->0 detected in a registered copy of en_i).
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset, then sample_i=0x0100 (1.0), scale_i=10, refrac_i=0, ready=1, en_i high at cycle 0 -> spike_o first high at cycle 12, isi_o=10, spike_o pulses every 12 cycles.
- sample_i=0x8000 (negative), scale_i=50 -> clamp, N=1, isi_o=1, spike_o at cycle 3; sample_i=0x0000 likewise gives N=1.
- CNT_WID=12, sample_i=0x7FFF, scale_i=255 -> p>>8=32639 saturates, isi_o=0x0FFF, spike at cycle 4097.
- N=10, spike_ready_i held 0 for 5 cycles in FIRE with en_i dropped -> spike_o stays 1 and isi_o stable; on ready, single handshake, then IDLE, busy_o=0.
- refrac_i=4, N=3, ready=1 -> FIRE, 4 REFRAC cycles, LOAD, 3 COUNT; spike period 9 cycles. en_i drop during COUNT -> IDLE next cycle, no spike.
- Assert rst_i asynchronously mid-COUNT and mid-FIRE -> spike_o, isi_o, busy_o go 0 before the next edge. With SPIKE_CNT_EN, 3 accepted spikes -> spike_cnt_o=3; en_i falling -> 0.

Source files
------------

// File: rtl/exp_isi_spike_gen.sv
// -----------------------------------------------------------------------------
// exp_isi_spike_gen
//
// Turns a free-running stream of signed fixed-point exponential samples into a
// Poisson spike train. Each sample is treated as an inter-spike interval (ISI):
// it is clamped at zero, scaled by a programmable rate factor, counted down,
// and then presented as a spike on a valid/ready handshake. An optional
// refractory period follows every accepted spike.
//
// Optional feature (compile-time macro SPIKE_CNT_EN):
//   Adds spike_cnt_o, a 16-bit saturating count of accepted spikes, cleared
//   by rst_i or synchronously when en_i falls.
//
// Ports:
//   clk_i          clock
//   rst_i          asynchronous active-high reset
//   en_i           generator enable
//   sample_i       signed exponential sample, FRAC_WID fractional bits
//   scale_i        cycles per unit of sample (mean ISI = scale_i cycles)
//   refrac_i       refractory cycles after each accepted spike, 0 = none
//   spike_o        spike event valid
//   spike_ready_i  downstream accepts spike
//   isi_o          interval that produced the current spike
//   busy_o         high whenever the generator is not idle
//   spike_cnt_o    accepted spike count (SPIKE_CNT_EN only)
//
// The interval product is X_WID+SCALE_WID bits wide and is assumed wider
// than CNT_WID, so the saturation test always has upper bits to inspect.
// -----------------------------------------------------------------------------
module exp_isi_spike_gen #(
    parameter int X_WID      = 16,
    parameter int FRAC_WID   = 8,
    parameter int SCALE_WID  = 8,
    parameter int CNT_WID    = 16,
    parameter int REFRAC_WID = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic [X_WID-1:0]      sample_i,
    input  logic [SCALE_WID-1:0]  scale_i,
    input  logic [REFRAC_WID-1:0] refrac_i,
    output logic                  spike_o,
    input  logic                  spike_ready_i,
    output logic [CNT_WID-1:0]    isi_o,
    output logic                  busy_o
`ifdef SPIKE_CNT_EN
    ,
    output logic [15:0]           spike_cnt_o
`endif
);

    localparam int P_WID   = X_WID + SCALE_WID;
    // One counter serves both the ISI countdown and the refractory period.
    localparam int CTR_WID = (CNT_WID > REFRAC_WID) ? CNT_WID : REFRAC_WID;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        COUNT,
        FIRE,
        REFRAC
    } state_t;

    state_t               state_q, state_d;
    logic [CTR_WID-1:0]   ctr_q, ctr_d;
    logic [CNT_WID-1:0]   isi_q, isi_d;
    logic                 handshake;

    // ---------------------------------------------------------------------
    // Interval arithmetic: N = sat(max(sample,0) * scale >> FRAC_WID), N >= 1
    // ---------------------------------------------------------------------
    logic [X_WID-1:0]   clamped;
    logic [P_WID-1:0]   product;
    logic [P_WID-1:0]   shifted;
    logic [CNT_WID-1:0] interval;

    // A set sign bit means a negative sample, which carries no interval.
    assign clamped = sample_i[X_WID-1] ? '0 : sample_i;
    assign product = {{SCALE_WID{1'b0}}, clamped} * {{X_WID{1'b0}}, scale_i};
    assign shifted = product >> FRAC_WID;

    always_comb begin
        if (shifted > P_WID'({CNT_WID{1'b1}})) begin
            interval = '1;
        end else if (shifted == '0) begin
            // A zero interval would need a zero-length COUNT; force one cycle.
            interval = CNT_WID'(1);
        end else begin
            interval = shifted[CNT_WID-1:0];
        end
    end

    // ---------------------------------------------------------------------
    // State and datapath registers
    // ---------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ctr_q   <= '0;
            isi_q   <= '0;
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
            isi_q   <= isi_d;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        ctr_d     = ctr_q;
        isi_d     = isi_q;
        handshake = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (en_i) state_d = LOAD;
            end

            LOAD: begin
                ctr_d   = CTR_WID'(interval);
                isi_d   = interval;
                state_d = COUNT;
            end

            COUNT: begin
                if (!en_i) begin
                    // Abandon the interval; no spike is owed.
                    ctr_d   = '0;
                    state_d = IDLE;
                end else begin
                    ctr_d = ctr_q - CTR_WID'(1);
                    if (ctr_q == CTR_WID'(1)) state_d = FIRE;
                end
            end

            FIRE: begin
                // en_i is deliberately ignored: a pending spike is never lost.
                if (spike_ready_i) begin
                    handshake = 1'b1;
                    if (refrac_i != '0) begin
                        ctr_d   = CTR_WID'(refrac_i);
                        state_d = REFRAC;
                    end else begin
                        state_d = en_i ? LOAD : IDLE;
                    end
                end
            end

            REFRAC: begin
                // Runs to completion even if en_i drops.
                ctr_d = ctr_q - CTR_WID'(1);
                if (ctr_q == CTR_WID'(1)) state_d = en_i ? LOAD : IDLE;
            end

            default: begin
                state_d = IDLE;
                ctr_d   = '0;
            end
        endcase
    end

    assign spike_o = (state_q == FIRE);
    assign isi_o   = isi_q;
    assign busy_o  = (state_q != IDLE);

`ifdef SPIKE_CNT_EN
    // ---------------------------------------------------------------------
    // Accepted-spike counter, cleared on a falling edge of en_i
    // ---------------------------------------------------------------------
    logic        en_q;
    logic [15:0] spike_cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            en_q        <= 1'b0;
            spike_cnt_q <= '0;
        end else begin
            en_q <= en_i;
            if (en_q && !en_i) begin
                spike_cnt_q <= '0;
            end else if (handshake && (spike_cnt_q != 16'hFFFF)) begin
                spike_cnt_q <= spike_cnt_q + 16'd1;
            end
        end
    end

    assign spike_cnt_o = spike_cnt_q;
`endif

endmodule
